// File: rtl/data_sa_pkg.sv
// Shared definitions for the ping/pong systolic-array input buffer:
// default geometry, index typedefs, fill-count type and half selectors.
package data_sa_pkg;

   localparam int DEF_NUM_CH     = 16;
   localparam int DEF_DEPTH      = 1024;
   localparam int DEF_DATA_WIDTH = 8;

   localparam int CH_W   = $clog2(DEF_NUM_CH);
   localparam int ADDR_W = $clog2(DEF_DEPTH);

   typedef logic [CH_W-1:0]        ch_idx_t;
   typedef logic [ADDR_W-1:0]      addr_t;
   typedef logic [CH_W+ADDR_W-1:0] rd_index_t;

   // Number of halves currently full and waiting for (or owned by) the reader.
   typedef enum logic [1:0] {
      FC_EMPTY = 2'd0,
      FC_ONE   = 2'd1,
      FC_FULL  = 2'd2
   } full_cnt_t;

   localparam logic HALF_PING = 1'b0;
   localparam logic HALF_PONG = 1'b1;

endpackage

// File: rtl/data_sa_pingpong_buff_if.sv
// Producer/consumer bus of the ping/pong input buffer.
// master: im2col/DMA writer plus SA feeder reader; slave: the buffer.
interface data_sa_pingpong_buff_if #(
   parameter int NUM_CH     = 16,
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 8
) ();
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(NUM_CH);

   logic [NUM_CH-1:0]                 wea;
   logic [NUM_CH-1:0][AW-1:0]         addra;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] dia;
   logic                              wr_done;
   logic                              wr_ready;
   logic                              wr_ovf;
   logic                              rd_en;
   logic                              rd_wide;
   logic [CW+AW-1:0]                  addrb;
   logic                              rd_done;
   logic                              rd_ready;
   logic                              rd_valid;
   logic [DATA_WIDTH-1:0]             dob;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] dob_wide;

   modport master (
      output wea, addra, dia, wr_done, rd_en, rd_wide, addrb, rd_done,
      input  wr_ready, wr_ovf, rd_ready, rd_valid, dob, dob_wide
   );

   modport slave (
      input  wea, addra, dia, wr_done, rd_en, rd_wide, addrb, rd_done,
      output wr_ready, wr_ovf, rd_ready, rd_valid, dob, dob_wide
   );
endinterface

// File: rtl/simple_dual_one_clock.sv
// Simple dual-port RAM, one clock: port A writes, port B reads with a
// one-cycle registered output. Contents are not reset.
module simple_dual_one_clock #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              ena,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [WIDTH-1:0]  dia,
   input  logic              enb,
   input  logic [ADDR_W-1:0] addrb,
   output logic [WIDTH-1:0]  dob
);
   logic [WIDTH-1:0] ram [DEPTH];

   // write port
   always_ff @(posedge clk) begin
      if (ena && wea) begin
         ram[addra] <= dia;
      end
   end

   // registered read port
   always_ff @(posedge clk) begin
      if (enb) begin
         dob <= ram[addrb];
      end
   end
endmodule

// File: rtl/data_sa_pingpong_buff.sv
// Ping/pong banked input buffer for the systolic array.
// One RAM bank per channel, each holding both halves ({half, local addr}).
// The writer fills wr_half while the reader drains rd_half; full_cnt tracks
// how many halves are closed and not yet released by the reader.
// Optional wide read (one element from every channel per cycle) is enabled
// by defining DATA_SA_BUFF_WIDE_READ_EN; otherwise rd_wide is ignored and
// dob_wide stays 0.
module data_sa_pingpong_buff
   import data_sa_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input logic clk,
   input logic rst,
   data_sa_pingpong_buff_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(NUM_CH);

   full_cnt_t full_cnt;
   full_cnt_t full_cnt_nxt;
   logic      wr_half;
   logic      rd_half;
   logic      wr_ready_q;
   logic      rd_ready_q;
   logic      wr_ovf_q;
   logic      rd_valid_q;
   logic [CW-1:0] rd_ch_q;

   logic          wr_close;
   logic          rd_close;
   logic          rd_acc;
   logic          rd_wide_eff;
   logic [CW-1:0] rd_ch;
   logic [AW-1:0] rd_addr;

   logic [NUM_CH-1:0]                 bank_we;
   logic [NUM_CH-1:0]                 bank_re;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] bank_dob;
   logic [DATA_WIDTH-1:0]             dob_mux;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] dob_wide_mux;

   assign wr_close = bus.wr_done & wr_ready_q;
   assign rd_close = bus.rd_done & rd_ready_q;
   assign rd_acc   = bus.rd_en   & rd_ready_q;
   assign rd_ch    = bus.addrb[CW+AW-1:AW];
   assign rd_addr  = bus.addrb[AW-1:0];

`ifdef DATA_SA_BUFF_WIDE_READ_EN
   logic rd_wide_q;
   assign rd_wide_eff = bus.rd_wide;
`else
   logic unused_rd_wide;
   assign unused_rd_wide = bus.rd_wide;
   assign rd_wide_eff    = 1'b0;
`endif

   // ownership next state: writer closes a half, reader releases one
   always_comb begin
      full_cnt_nxt = full_cnt;
      case (full_cnt)
         FC_EMPTY: begin
            if (wr_close) full_cnt_nxt = FC_ONE;
            else          full_cnt_nxt = FC_EMPTY;
         end
         FC_ONE: begin
            if (wr_close && !rd_close)      full_cnt_nxt = FC_FULL;
            else if (!wr_close && rd_close) full_cnt_nxt = FC_EMPTY;
            else                            full_cnt_nxt = FC_ONE;
         end
         FC_FULL: begin
            if (rd_close) full_cnt_nxt = FC_ONE;
            else          full_cnt_nxt = FC_FULL;
         end
         default: full_cnt_nxt = FC_EMPTY;
      endcase
   end

   // ownership state, half pointers, ready flags and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_cnt   <= FC_EMPTY;
         wr_half    <= HALF_PING;
         rd_half    <= HALF_PING;
         wr_ready_q <= 1'b1;
         rd_ready_q <= 1'b0;
         wr_ovf_q   <= 1'b0;
      end else begin
         full_cnt   <= full_cnt_nxt;
         wr_half    <= wr_half ^ wr_close;
         rd_half    <= rd_half ^ rd_close;
         wr_ready_q <= (full_cnt_nxt != FC_FULL);
         rd_ready_q <= (full_cnt_nxt != FC_EMPTY);
         wr_ovf_q   <= wr_ovf_q | (~wr_ready_q & ((|bus.wea) | bus.wr_done));
      end
   end

   // read request pipeline: valid, channel and mode travel with the data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_ch_q    <= '0;
`ifdef DATA_SA_BUFF_WIDE_READ_EN
         rd_wide_q  <= 1'b0;
`endif
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_ch_q   <= rd_ch;
`ifdef DATA_SA_BUFF_WIDE_READ_EN
            rd_wide_q <= rd_wide_eff;
`endif
         end
      end
   end

   // bank enables: writes gated by ownership, reads hit one bank or all
   always_comb begin
      bank_we = '0;
      bank_re = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bank_we[i] = bus.wea[i] & wr_ready_q;
         bank_re[i] = rd_acc & (rd_wide_eff | (rd_ch == CW'(i)));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
      simple_dual_one_clock #(
         .WIDTH (DATA_WIDTH),
         .DEPTH (2 * DEPTH)
      ) u_ram (
         .clk   (clk),
         .ena   (bank_we[g]),
         .wea   (1'b1),
         .addra ({wr_half, bus.addra[g]}),
         .dia   (bus.dia[g]),
         .enb   (bank_re[g]),
         .addrb ({rd_half, rd_addr}),
         .dob   (bank_dob[g])
      );
   end

   // read data steering; outputs are zero whenever no read completes
   always_comb begin
      dob_mux      = '0;
      dob_wide_mux = '0;
      if (rd_valid_q) begin
         dob_mux = bank_dob[rd_ch_q];
`ifdef DATA_SA_BUFF_WIDE_READ_EN
         if (rd_wide_q) dob_wide_mux = bank_dob;
         else           dob_wide_mux = '0;
`endif
      end else begin
         dob_mux      = '0;
         dob_wide_mux = '0;
      end
   end

   assign bus.wr_ready = wr_ready_q;
   assign bus.rd_ready = rd_ready_q;
   assign bus.wr_ovf   = wr_ovf_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.dob      = dob_mux;
   assign bus.dob_wide = dob_wide_mux;
endmodule

// File: tb/tb_data_sa_pingpong_buff.sv
// Self-checking bench for data_sa_pingpong_buff: a half-level model
// (memory per half, fill count, expected read) checked every cycle,
// plus directed scenarios with literal expectations.
module tb_data_sa_pingpong_buff;
   localparam int NCH = 16;
   localparam int DEP = 1024;
   localparam int DW  = 8;
`ifdef DATA_SA_BUFF_WIDE_READ_EN
   localparam bit WIDE_EN = 1'b1;
`else
   localparam bit WIDE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   data_sa_pingpong_buff_if #(.NUM_CH(NCH), .DEPTH(DEP), .DATA_WIDTH(DW)) bus ();

   data_sa_pingpong_buff #(.NUM_CH(NCH), .DEPTH(DEP), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string nm, input logic [NCH*DW-1:0] act, input logic [NCH*DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] mem [2][NCH][DEP];
   bit            kn  [2][NCH][DEP];
   int            m_cnt;
   bit            m_wh, m_rh, m_ovf;
   bit            e_valid, e_wide, e_kn, e_wkn;
   logic [DW-1:0] e_dob;
   logic [NCH*DW-1:0] e_wdata;

   function automatic bit all_known(input bit h, input int a);
      for (int c = 0; c < NCH; c++) if (!kn[h][c][a]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [NCH*DW-1:0] wide_word(input bit h, input int a);
      logic [NCH*DW-1:0] w;
      for (int c = 0; c < NCH; c++) w[c*DW +: DW] = mem[h][c][a];
      return w;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cnt <= 0; m_wh <= 1'b0; m_rh <= 1'b0; m_ovf <= 1'b0;
         e_valid <= 1'b0; e_wide <= 1'b0;
         for (int h = 0; h < 2; h++)
            for (int c = 0; c < NCH; c++)
               for (int a = 0; a < DEP; a++) kn[h][c][a] <= 1'b0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (bus.wea[c] && m_cnt < 2) begin
               mem[m_wh][c][bus.addra[c]] <= bus.dia[c];
               kn[m_wh][c][bus.addra[c]]  <= 1'b1;
            end
         end
         if (((|bus.wea) || bus.wr_done) && m_cnt == 2) m_ovf <= 1'b1;
         if (bus.wr_done && m_cnt < 2) m_wh <= ~m_wh;
         if (bus.rd_done && m_cnt > 0) m_rh <= ~m_rh;
         m_cnt <= m_cnt + ((bus.wr_done && m_cnt < 2) ? 1 : 0)
                        - ((bus.rd_done && m_cnt > 0) ? 1 : 0);
         e_valid <= bus.rd_en && m_cnt > 0;
         e_wide  <= bus.rd_en && m_cnt > 0 && WIDE_EN && bus.rd_wide;
         e_dob   <= mem[m_rh][bus.addrb[13:10]][bus.addrb[9:0]];
         e_kn    <= kn[m_rh][bus.addrb[13:10]][bus.addrb[9:0]];
         e_wdata <= wide_word(m_rh, int'(bus.addrb[9:0]));
         e_wkn   <= all_known(m_rh, int'(bus.addrb[9:0]));
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("wr_ready", bus.wr_ready, (m_cnt < 2));
         chk("rd_ready", bus.rd_ready, (m_cnt > 0));
         chk("wr_ovf",   bus.wr_ovf,   m_ovf);
         chk("rd_valid", bus.rd_valid, e_valid);
         if (!e_valid) begin
            chk("dob_idle",      bus.dob,      '0);
            chk("dob_wide_idle", bus.dob_wide, '0);
         end else if (!e_wide) begin
            if (e_kn) chk("dob", bus.dob, e_dob);
            if (!WIDE_EN) chk("dob_wide_off", bus.dob_wide, '0);
         end else if (e_wkn) begin
            chk("dob_wide", bus.dob_wide, e_wdata);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clr();
      bus.wea = '0; bus.addra = '0; bus.dia = '0; bus.wr_done = 1'b0;
      bus.rd_en = 1'b0; bus.rd_wide = 1'b0; bus.addrb = '0; bus.rd_done = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_wr_ready", bus.wr_ready, 1'b1);
      chk("rst_rd_ready", bus.rd_ready, 1'b0);
      chk("rst_wr_ovf",   bus.wr_ovf,   1'b0);
      chk("rst_rd_valid", bus.rd_valid, 1'b0);
      chk("rst_dob",      bus.dob,      '0);

      // read while empty is ignored
      bus.rd_en = 1'b1; bus.addrb = {4'd3, 10'd5}; tick(); clr();
      chk("empty_rd_valid", bus.rd_valid, 1'b0);
      chk("empty_dob",      bus.dob,      '0);

      // single write, hand over, single read
      bus.wea[3] = 1'b1; bus.addra[3] = 10'd5; bus.dia[3] = 8'hA5; tick(); clr();
      bus.wr_done = 1'b1;
      chk("pre_rd_ready", bus.rd_ready, 1'b0);
      tick(); clr();
      chk("post_rd_ready", bus.rd_ready, 1'b1);
      bus.rd_en = 1'b1; bus.addrb = {4'd3, 10'd5}; tick(); clr();
      chk("single_rd_valid", bus.rd_valid, 1'b1);
      chk("single_dob", bus.dob, 8'hA5);
      tick();
      chk("single_rd_valid_drop", bus.rd_valid, 1'b0);

      // release, fill all channels at addr 7, wide read
      bus.rd_done = 1'b1; tick(); clr();
      chk("release_rd_ready", bus.rd_ready, 1'b0);
      for (int i = 0; i < NCH; i++) begin
         bus.wea[i] = 1'b1; bus.addra[i] = 10'd7; bus.dia[i] = 8'h10 + 8'(i);
      end
      tick(); clr();
      bus.wr_done = 1'b1; tick(); clr();
      bus.rd_en = 1'b1; bus.rd_wide = 1'b1; bus.addrb = {4'd0, 10'd7}; tick(); clr();
`ifdef DATA_SA_BUFF_WIDE_READ_EN
      for (int i = 0; i < NCH; i++) chk("wide_slice", bus.dob_wide[i], 8'h10 + 8'(i));
`else
      chk("wide_off_dob_wide", bus.dob_wide, '0);
      chk("wide_off_dob", bus.dob, 8'h10);
`endif
      tick();

      // simultaneous close and release at one full half
      bus.wea[2] = 1'b1; bus.addra[2] = 10'd9; bus.dia[2] = 8'h3C;
      bus.wea[1] = 1'b1; bus.addra[1] = 10'd4; bus.dia[1] = 8'h77;
      bus.wr_done = 1'b1; bus.rd_done = 1'b1; tick(); clr();
      chk("swap_rd_ready", bus.rd_ready, 1'b1);
      chk("swap_wr_ready", bus.wr_ready, 1'b1);
      bus.rd_en = 1'b1; bus.addrb = {4'd2, 10'd9}; tick(); clr();
      chk("swap_dob", bus.dob, 8'h3C);

      // both halves full: further write and wr_done dropped
      bus.wea[1] = 1'b1; bus.addra[1] = 10'd4; bus.dia[1] = 8'h11;
      bus.wr_done = 1'b1; tick(); clr();
      chk("full_wr_ready", bus.wr_ready, 1'b0);
      chk("full_wr_ovf_clear", bus.wr_ovf, 1'b0);
      bus.wea[1] = 1'b1; bus.addra[1] = 10'd4; bus.dia[1] = 8'hEE;
      bus.wr_done = 1'b1; tick(); clr();
      chk("ovf_set", bus.wr_ovf, 1'b1);
      chk("ovf_wr_ready", bus.wr_ready, 1'b0);
      bus.rd_en = 1'b1; bus.addrb = {4'd1, 10'd4}; tick(); clr();
      chk("ovf_half_intact", bus.dob, 8'h77);
      tick();
      chk("ovf_sticky", bus.wr_ovf, 1'b1);

      // reset in the middle of a read with both halves full
      bus.rd_en = 1'b1; bus.addrb = {4'd2, 10'd9}; tick(); clr();
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_ready", bus.wr_ready, 1'b1);
      chk("mid_rst_rd_ready", bus.rd_ready, 1'b0);
      chk("mid_rst_rd_valid", bus.rd_valid, 1'b0);
      chk("mid_rst_wr_ovf",   bus.wr_ovf,   1'b0);
      chk("mid_rst_dob",      bus.dob,      '0);
      tick(); tick();
      rst = 1'b0;

      // highest channel and address, written in the closing cycle
      bus.wea[15] = 1'b1; bus.addra[15] = 10'd1023; bus.dia[15] = 8'hFF;
      bus.wr_done = 1'b1; tick(); clr();
      bus.rd_en = 1'b1; bus.addrb = {4'd15, 10'd1023}; tick(); clr();
      chk("edge_dob", bus.dob, 8'hFF);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/data_sa_pingpong_buff.md
# data_sa_pingpong_buff

Double-buffered (ping/pong) banked input-data buffer feeding the systolic array. NUM_CH independent per-channel write lanes fill one half while the array reads the other half, either one element at a time through a flat channel/address index or, in wide mode, one element from every channel per cycle. Half ownership is tracked by full/empty handshakes, so the producer (im2col/DMA side) and consumer (SA feeder) never touch the same half.

## Interface
- NUM_CH, 16, number of channels/banks (power of two, ≥2)
- DEPTH, 1024, entries per channel per half (power of two)
- DATA_WIDTH, 8, element width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- wea  in  NUM_CH  per-channel write enable
- addra  in  NUM_CH x $clog2(DEPTH)  per-channel write address within current write half
- dia  in  NUM_CH x DATA_WIDTH  per-channel write data
- wr_done  in  1  producer finished filling current write half
- wr_ready  out  1  a free half is owned by the writer
- wr_ovf  out  1  sticky: write or wr_done attempted while wr_ready=0
- rd_en  in  1  read request
- rd_wide  in  1  1 = wide read (all channels), 0 = single element
- addrb  in  $clog2(NUM_CH)+$clog2(DEPTH)  read index; upper bits = channel, lower bits = address (wide mode uses lower bits only)
- rd_done  in  1  consumer finished with current read half
- rd_ready  out  1  a full half is owned by the reader
- rd_valid  out  1  read data valid
- dob  out  DATA_WIDTH  single-element read data
- dob_wide  out  NUM_CH x DATA_WIDTH  wide read data, channel i in slice i

## Operation
- Each bank is 2*DEPTH deep; physical address = {half bit, local address}.
- State: wr_half, rd_half (1 bit each), full_cnt (0..2). wr_ready = (full_cnt<2); rd_ready = (full_cnt>0).
- Write: for each i with wea[i]=1 and wr_ready=1, bank i stores dia[i] at {wr_half, addra[i]}. wea while wr_ready=0 is dropped, sets wr_ovf.
- wr_done with wr_ready=1: wr_half toggles, full_cnt+1. wr_done with wr_ready=0: ignored, sets wr_ovf. Writes in the wr_done cycle land in the half being closed.
- Read accepted when rd_en=1 and rd_ready=1; otherwise ignored, no error flag. Single mode: only bank addrb channel field is enabled; wide mode: all banks enabled at same local address.
- rd_done with rd_ready=1: rd_half toggles, full_cnt-1; rd_done with rd_ready=0 ignored. A read accepted in the rd_done cycle uses the old half and completes normally.
- Simultaneous accepted wr_done and rd_done: both halves toggle, full_cnt unchanged.
- Out-of-range channel field cannot occur (NUM_CH power of two).

## Timing
- Reset values: wr_half=0, rd_half=0, full_cnt=0, wr_ready=1, rd_ready=0, wr_ovf=0, rd_valid=0, dob=0, dob_wide=0.
- Write latency 1 cycle; data readable once its half is handed over via wr_done (rd_ready next cycle).
- Read latency 1: rd_valid high in cycle N+1 for a read accepted in N; channel select and mode registered with the request. dob/dob_wide forced to 0 when rd_valid=0.
- Back-to-back reads every cycle; throughput 1 element (single) or NUM_CH elements (wide) per cycle.
- Reset mid-operation: all state returns to reset values immediately; SRAM contents undefined, both halves treated empty.

## Configuration
- DATA_SA_BUFF_WIDE_READ_EN defined: rd_wide and dob_wide functional as above.
- Not defined: rd_wide ignored (always single mode), dob_wide tied to 0, only the selected bank is ever enabled.

## Structure
- Shared package data_sa_pkg: channel-index and address typedefs derived from NUM_CH/DEPTH, full_cnt type, half-select constants.
- One sub-module: simple_dual_one_clock (one instance per channel, depth 2*DEPTH); ownership FSM and read mux in this module.

## Test plan
- Reset, write ch3 addr5=0xA5, wr_done, read addrb={3,5} single -> rd_ready=1 cycle after wr_done, rd_valid one cycle after rd_en, dob=0xA5.
- Fill half 0 with dia[i]=i+0x10 at addr 7, wr_done, wide read addr 7 -> dob_wide slice i = i+0x10 for all 16 channels (macro defined); macro undefined -> dob_wide=0.
- Two wr_done with no rd_done -> wr_ready=0; third write and wr_done dropped, wr_ovf=1, half contents unchanged.
- rd_en with full_cnt=0 -> rd_valid stays 0, dob=0.
- Simultaneous wr_done and rd_done at full_cnt=1 -> full_cnt stays 1, next read returns data from newly closed half.
- Assert rst mid-stream with full_cnt=2 -> next cycle wr_ready=1, rd_ready=0, rd_valid=0, wr_ovf=0.
